// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM encoding, PC geometry and the EX-resolution bundle.
// The bundle layout is also used by the predictor and the hazard unit.
package pipe_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int unsigned    PC_W           = 32;
    localparam int unsigned    INSN_BYTES_DEF = 4;
    localparam logic [PC_W-1:0] RESET_PC      = 32'h0;
    localparam int unsigned    FLUSH_CNT_W    = 4;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] pred_pc;
    } ex_res_t;

    // Modulo-2^32 add, so the last word of the address space wraps to 0.
    function automatic logic [PC_W-1:0] resolve_next_pc(input ex_res_t r,
                                                        input logic [PC_W-1:0] step);
        return r.taken ? r.target : r.pc + step;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// EX-resolution inputs and redirect/flush/training outputs of the branch resolve controller.
// master = pipeline side driving EX, slave = the controller.
interface branch_resolve_ctrl_if
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic            pipe_stall;
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_pc;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] ex_pred_pc;

    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             branch_flag;
    logic [PC_W-1:0]  branch_from_pc;
    logic [PC_W-1:0]  branch_to_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;
    logic             busy;

    modport master (
        output pipe_stall, ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, ex_pred_pc,
        input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex, branch_flag,
               branch_from_pc, branch_to_pc, br_count, miss_count, busy
    );

    modport slave (
        input  pipe_stall, ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, ex_pred_pc,
        output redirect_valid, redirect_pc, flush_if_id, flush_id_ex, branch_flag,
               branch_from_pc, branch_to_pc, br_count, miss_count, busy
    );

endinterface

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency 1 cycle from inc to q; no backpressure.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Misprediction recovery: redirect + fixed flush window on a wrong prediction, predictor training strobe, stats.
// Outputs 1 cycle after the accept edge; pipe_stall blocks acceptance but never stretches a flush.
module branch_resolve_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned INSN_BYTES   = INSN_BYTES_DEF,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_ctrl_if.slave bus
);
    state_e                 state_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    logic                   redirect_valid_q;
    logic                   flush_q;
    logic                   branch_flag_q;
    logic [PC_W-1:0]        redirect_pc_q;
    logic [PC_W-1:0]        branch_from_q;
    logic [PC_W-1:0]        branch_to_q;

    ex_res_t         ex;
    logic [PC_W-1:0] actual;
    logic            acc;
    logic            miss;
    logic            train;

    assign ex = '{taken:   bus.ex_taken,
                  pc:      bus.ex_pc,
                  target:  bus.ex_target,
                  pred_pc: bus.ex_pred_pc};

    assign actual = resolve_next_pc(ex, PC_W'(INSN_BYTES));
    // Anything reaching EX while in FLUSH is wrong-path and must not count or train.
    assign acc    = bus.ex_valid & bus.ex_is_branch & ~bus.pipe_stall & (state_q == ST_RUN);
    assign miss   = acc & (actual != ex.pred_pc);
    assign train  = acc & ex.taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            flush_cnt_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            branch_flag_q    <= 1'b0;
            branch_from_q    <= '0;
            branch_to_q      <= '0;
        end else begin
            redirect_valid_q <= miss;
            branch_flag_q    <= train;
            if (miss) begin
                redirect_pc_q <= actual;
            end
            if (train) begin
                branch_from_q <= ex.pc;
                branch_to_q   <= ex.target;
            end

            case (state_q)
                ST_RUN: begin
                    if (miss) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_CNT_W'(FLUSH_CYCLES);
                        flush_q     <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Counts through stalls so the squash window is always exactly FLUSH_CYCLES.
                    if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
                        state_q     <= ST_RUN;
                        flush_cnt_q <= '0;
                        flush_q     <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    flush_cnt_q <= '0;
                    flush_q     <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (acc),
        .q     (bus.br_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss),
        .q     (bus.miss_count)
    );

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if_id    = flush_q;
    assign bus.flush_id_ex    = flush_q;
    assign bus.busy           = flush_q;
    assign bus.branch_flag    = branch_flag_q;
    assign bus.branch_from_pc = branch_from_q;
    assign bus.branch_to_pc   = branch_to_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: main instance with 32-bit counters, second with 4-bit counters for saturation.
module tb_branch_resolve_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_resolve_ctrl_if #(.CNT_W(32)) bus_m ();
    branch_resolve_ctrl_if #(.CNT_W(4))  bus_s ();

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .INSN_BYTES(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .INSN_BYTES(4), .CNT_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic tk,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] pred, input logic st);
        bus_m.ex_valid     = v;
        bus_m.ex_is_branch = br;
        bus_m.ex_taken     = tk;
        bus_m.ex_pc        = pc;
        bus_m.ex_target    = tgt;
        bus_m.ex_pred_pc   = pred;
        bus_m.pipe_stall   = st;
    endtask

    task automatic drive_s(input logic v, input logic tk, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic [31:0] pred);
        bus_s.ex_valid     = v;
        bus_s.ex_is_branch = v;
        bus_s.ex_taken     = tk;
        bus_s.ex_pc        = pc;
        bus_s.ex_target    = tgt;
        bus_s.ex_pred_pc   = pred;
        bus_s.pipe_stall   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".redirect_valid"}, 32'(bus_m.redirect_valid), 32'h0);
        chk({tag, ".redirect_pc"},    bus_m.redirect_pc,         32'h0);
        chk({tag, ".flush_if_id"},    32'(bus_m.flush_if_id),    32'h0);
        chk({tag, ".flush_id_ex"},    32'(bus_m.flush_id_ex),    32'h0);
        chk({tag, ".busy"},           32'(bus_m.busy),           32'h0);
        chk({tag, ".branch_flag"},    32'(bus_m.branch_flag),    32'h0);
        chk({tag, ".from_pc"},        bus_m.branch_from_pc,      32'h0);
        chk({tag, ".to_pc"},          bus_m.branch_to_pc,        32'h0);
        chk({tag, ".br_count"},       bus_m.br_count,            32'h0);
        chk({tag, ".miss_count"},     bus_m.miss_count,          32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive_s(0, 0, 0, 0, 0);

        // Reset state
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct not-taken
        drive(1, 1, 0, 32'h40, 32'h0, 32'h44, 0);
        tick();
        chk("nt.redirect_valid", 32'(bus_m.redirect_valid), 0);
        chk("nt.branch_flag",    32'(bus_m.branch_flag),    0);
        chk("nt.flush",          32'(bus_m.flush_if_id),    0);
        chk("nt.br_count",       bus_m.br_count,            1);
        chk("nt.miss_count",     bus_m.miss_count,          0);

        // Cold taken miss, then wrong-path branches held in EX during the flush
        drive(1, 1, 1, 32'h40, 32'h10, 32'h44, 0);
        tick();
        chk("miss.redirect_valid", 32'(bus_m.redirect_valid), 1);
        chk("miss.redirect_pc",    bus_m.redirect_pc,         32'h10);
        chk("miss.branch_flag",    32'(bus_m.branch_flag),    1);
        chk("miss.from_pc",        bus_m.branch_from_pc,      32'h40);
        chk("miss.to_pc",          bus_m.branch_to_pc,        32'h10);
        chk("miss.flush_if_id",    32'(bus_m.flush_if_id),    1);
        chk("miss.flush_id_ex",    32'(bus_m.flush_id_ex),    1);
        chk("miss.busy",           32'(bus_m.busy),           1);
        chk("miss.miss_count",     bus_m.miss_count,          1);
        chk("miss.br_count",       bus_m.br_count,            2);
        drive(1, 1, 1, 32'h80, 32'h20, 32'h84, 0);
        tick();
        chk("wp1.redirect_valid", 32'(bus_m.redirect_valid), 0);
        chk("wp1.branch_flag",    32'(bus_m.branch_flag),    0);
        chk("wp1.flush",          32'(bus_m.flush_if_id),    1);
        chk("wp1.br_count",       bus_m.br_count,            2);
        tick();
        chk("wp2.flush",          32'(bus_m.flush_id_ex),    0);
        chk("wp2.busy",           32'(bus_m.busy),           0);
        chk("wp2.br_count",       bus_m.br_count,            2);
        chk("wp2.miss_count",     bus_m.miss_count,          1);
        chk("wp2.held_redir_pc",  bus_m.redirect_pc,         32'h10);
        chk("wp2.held_from_pc",   bus_m.branch_from_pc,      32'h40);

        // Stale taken entry, branch actually not taken
        drive(1, 1, 0, 32'h40, 32'h0, 32'h10, 0);
        tick();
        chk("stale.redirect_valid", 32'(bus_m.redirect_valid), 1);
        chk("stale.redirect_pc",    bus_m.redirect_pc,         32'h44);
        chk("stale.branch_flag",    32'(bus_m.branch_flag),    0);
        chk("stale.held_to_pc",     bus_m.branch_to_pc,        32'h10);
        chk("stale.miss_count",     bus_m.miss_count,          2);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("stale.flush_done",     32'(bus_m.flush_if_id),    0);

        // Correctly predicted taken branch trains, then a back-to-back not-taken one
        drive(1, 1, 1, 32'h100, 32'h200, 32'h200, 0);
        tick();
        chk("hit.redirect_valid", 32'(bus_m.redirect_valid), 0);
        chk("hit.branch_flag",    32'(bus_m.branch_flag),    1);
        chk("hit.from_pc",        bus_m.branch_from_pc,      32'h100);
        chk("hit.to_pc",          bus_m.branch_to_pc,        32'h200);
        drive(1, 1, 0, 32'h200, 32'h0, 32'h204, 0);
        tick();
        chk("b2b.branch_flag",    32'(bus_m.branch_flag),    0);
        chk("b2b.br_count",       bus_m.br_count,            5);

        // Stalled miss for three cycles, then released
        drive(1, 1, 1, 32'h300, 32'h500, 32'h304, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.redirect_valid", 32'(bus_m.redirect_valid), 0);
        end
        chk("stall.br_count", bus_m.br_count, 5);
        bus_m.pipe_stall = 1'b0;
        tick();
        chk("rel.redirect_valid", 32'(bus_m.redirect_valid), 1);
        chk("rel.redirect_pc",    bus_m.redirect_pc,         32'h500);
        chk("rel.miss_count",     bus_m.miss_count,          3);
        // Stall raised inside the flush window must not extend it
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("fstall.redirect_once", 32'(bus_m.redirect_valid), 0);
        chk("fstall.flush_mid",     32'(bus_m.flush_if_id),    1);
        tick();
        chk("fstall.flush_end",     32'(bus_m.flush_if_id),    0);
        chk("fstall.busy_end",      32'(bus_m.busy),           0);
        bus_m.pipe_stall = 1'b0;

        // PC wrap at the top of the address space
        drive(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        tick();
        chk("wrap_hit.redirect_valid", 32'(bus_m.redirect_valid), 0);
        drive(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h4, 0);
        tick();
        chk("wrap_miss.redirect_valid", 32'(bus_m.redirect_valid), 1);
        chk("wrap_miss.redirect_pc",    bus_m.redirect_pc,         32'h0);
        chk("wrap_miss.br_count",       bus_m.br_count,            8);
        chk("wrap_miss.miss_count",     bus_m.miss_count,          4);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset one cycle into FLUSH clears everything without a clock edge
        drive(1, 1, 1, 32'h40, 32'h10, 32'h44, 0);
        tick();
        chk("pre_rst.busy", 32'(bus_m.busy), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 1, 32'h40, 32'h10, 32'h44, 0);
        tick();
        chk("post_rst.redirect_valid", 32'(bus_m.redirect_valid), 1);
        chk("post_rst.redirect_pc",    bus_m.redirect_pc,         32'h10);
        chk("post_rst.miss_count",     bus_m.miss_count,          1);
        chk("post_rst.flush",          32'(bus_m.flush_if_id),    1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("post_rst.flush_done",     32'(bus_m.flush_if_id),    0);

        // 20 misses into the 4-bit-counter instance
        drive_s(1, 1, 32'h40, 32'h10, 32'h44);
        for (int i = 0; i < 20; i++) begin
            tick();
            tick();
            tick();
        end
        drive_s(0, 0, 0, 0, 0);
        chk("sat.miss_count", 32'(bus_s.miss_count), 15);
        chk("sat.br_count",   32'(bus_s.br_count),   15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Misprediction recovery controller sitting between the execute stage and the fetch-side PC predictor. Each cycle it compares the resolved next PC of a branch or jump in EX with the PC the predictor supplied when that instruction was fetched. On a mismatch it issues a redirect and holds the IF/ID and ID/EX flushes for a fixed window. It also emits the one-cycle training strobe (`branch_flag`, from/to PC) consumed by the predictor, and keeps saturating branch and miss counters for the debug/UART path.

## Interface
- `FLUSH_CYCLES`, 2 — cycles flush stays asserted after a redirect; legal range 1–15.
- `INSN_BYTES`, 4 — sequential PC increment.
- `CNT_W`, 32 — width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pipe_stall`  in  1  pipeline hold; while high, EX inputs are not sampled.
- `ex_valid`  in  1  EX holds a live instruction.
- `ex_is_branch`  in  1  EX instruction is a conditional branch or jump.
- `ex_taken`  in  1  resolved direction; jumps drive 1.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_target`  in  32  resolved taken target.
- `ex_pred_pc`  in  32  prediction carried down the pipe with this instruction.
- `redirect_valid`  out  1  one-cycle pulse: fetch loads `redirect_pc`.
- `redirect_pc`  out  32  corrected next PC.
- `flush_if_id`, `flush_id_ex`  out  1 each  squash younger stages.
- `branch_flag`  out  1  one-cycle predictor training strobe.
- `branch_from_pc`, `branch_to_pc`  out  32 each  training pair.
- `br_count`, `miss_count`  out  `CNT_W` each  resolved-branch and misprediction counts.
- `busy`  out  1  high while in the FLUSH state.

## Operation
- **Accept condition:** `acc = ex_valid & ex_is_branch & ~pipe_stall & (state == RUN)`.
- **Resolved next PC:** `actual = ex_taken ? ex_target : ex_pc + INSN_BYTES`. Arithmetic is 32-bit modulo, so 0xFFFF_FFFC + 4 = 0.
- **Mispredict:** `miss = acc & (actual != ex_pred_pc)`.
- **FSM states:**
  - RUN (reset state). On `miss`: register `redirect_pc = actual`, pulse `redirect_valid`, load the flush counter with `FLUSH_CYCLES`, and go to FLUSH.
  - FLUSH: `flush_if_id = flush_id_ex = busy = 1`. The counter decrements each cycle, including cycles with `pipe_stall` high, because a flush must complete regardless of stall. At count 1, return to RUN. EX inputs are ignored because they are wrong-path.
- **Training:**
  - On `acc & ex_taken`, register `branch_flag = 1`, `branch_from_pc = ex_pc`, `branch_to_pc = ex_target`.
  - Not-taken branches never train, since the predictor only stores taken branches. A stale taken entry therefore keeps mispredicting and is recovered by redirect each time.
  - Training happens on hits and misses alike, so LRU recency is refreshed on every taken branch.
- **Counters:**
  - `br_count` increments on `acc`; `miss_count` increments on `miss`.
  - Both saturate at all-ones and never wrap.
- **Held values:** `branch_from_pc`, `branch_to_pc` and `redirect_pc` keep their last value when their strobe is low.
- **Reset:** asserting `rst_n` low at any point, including mid-FLUSH, forces RUN, clears the flush counter, and clears every output to 0 immediately, without waiting for a clock edge.

## Timing
- Resolution is combinational from the EX inputs; all outputs are registered.
- **Redirect latency:** `redirect_valid`, `redirect_pc` and the first flush cycle appear one cycle after the accept edge.
- **Flush window:** flush is high for exactly `FLUSH_CYCLES` consecutive cycles, starting in the same cycle as `redirect_valid`.
- **Training latency:** `branch_flag` rises one cycle after the accept edge and lasts one cycle. The predictor samples it on negedge, within that same cycle.
- **Simultaneous miss and taken:** the redirect and the training strobe fire in the same cycle.
- **Back-to-back branches in RUN:** each is accepted on consecutive cycles. A miss on the first suppresses acceptance of the second, which is already in FLUSH and wrong-path.
- **Stall:** with `pipe_stall` high in RUN, nothing is accepted, strobes stay 0, and counters hold.

## Structure
- **Shared package `pipe_pkg`:**
  - state encoding (RUN=0, FLUSH=1)
  - `INSN_BYTES` default
  - `RESET_PC` (32'h0)
  - the EX-resolution bundle field widths, which are shared with the predictor and the hazard unit.
- **Sub-module:** one natural sub-module, `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `q`), instantiated twice.
- **Top level:** the FSM and the flush down-counter stay in the top module.

## Test plan
- **Correct not-taken:** branch with `ex_pc=0x40`, `taken=0`, `pred=0x44`. Expect no redirect, `branch_flag=0`, `br_count=1`, `miss_count=0`.
- **Cold taken miss:** `ex_pc=0x40`, `taken=1`, `target=0x10`, `pred=0x44`. Next cycle expect `redirect_valid=1` with `redirect_pc=0x10`, and `branch_flag=1` with from=0x40, to=0x10. Flush is high for exactly 2 cycles, `miss_count=1`.
- **Wrong-path suppression:** valid taken branches are presented every cycle during FLUSH. Expect none counted or trained, and return to RUN after 2 cycles.
- **Stale taken entry, not-taken outcome:** `taken=0`, `pred=0x10`, `ex_pc=0x40`. Expect redirect to 0x44, `branch_flag` stays 0.
- **Stall interaction:** `pipe_stall=1` with a valid miss presented for 3 cycles, then released. Expect exactly one redirect, one cycle after release. Separately, with `pipe_stall` raised mid-FLUSH, flush still ends after `FLUSH_CYCLES`.
- **Reset mid-FLUSH and saturation:**
  - Drop `rst_n` low one cycle into FLUSH. Expect all outputs 0 at once, RUN restored, and a clean redirect on the next miss.
  - With `CNT_W=4`, drive 20 misses. Expect `miss_count` to stop at 15.
